// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the BCD sum scan display.
//   SEG_*     : active-high {g,f,e,d,c,b,a} glyph codes
//   digit_t   : digit slot index (ones, tens, hundreds)
//   bcd_val_t : latched adder result {cout, tens, ones}
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    DIG_ONES = 2'd0,
    DIG_TENS = 2'd1,
    DIG_HUND = 2'd2
  } digit_t;

  typedef struct packed {
    logic       cout;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_val_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Nibble to active-high 7-segment glyph; codes 10..15 render as 'E'.
//   nib     : input BCD nibble
//   glyph_c : combinational {g,f,e,d,c,b,a}
module bcd_to_seg7 (
  input  logic [3:0] nib,
  output logic [6:0] glyph_c
);
  import bcd_disp_pkg::*;

  always_comb begin
    glyph_c = SEG_E;
    case (nib)
      4'd0:    glyph_c = SEG_0;
      4'd1:    glyph_c = SEG_1;
      4'd2:    glyph_c = SEG_2;
      4'd3:    glyph_c = SEG_3;
      4'd4:    glyph_c = SEG_4;
      4'd5:    glyph_c = SEG_5;
      4'd6:    glyph_c = SEG_6;
      4'd7:    glyph_c = SEG_7;
      4'd8:    glyph_c = SEG_8;
      4'd9:    glyph_c = SEG_9;
      default: glyph_c = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_sum_scan_display.sv
// Latches a BCD sum plus carry (0..199) and scans it onto a 3-digit
// multiplexed 7-segment display. New values are held in a pending buffer
// and committed only at frame end, so a frame never shows a mixed value.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture {cout_in, sum_in} this edge
//   sum_in     : BCD {tens, ones}
//   cout_in    : hundreds digit (0/1)
//   seg, dp    : registered segment drive {g..a} and decimal point (unlit)
//   an         : registered digit enables {hundreds, tens, ones}
//   frame_tick : high during the commit cycle (last cycle of hundreds slot)
//   bcd_err    : displayed value contains a nibble above 9
module bcd_sum_scan_display #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLANK_CYC      = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] sum_in,
  input  logic       cout_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic [2:0] an,
  output logic       frame_tick,
  output logic       bcd_err
);
  import bcd_disp_pkg::*;

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0] AN_OFF  = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

  logic [PW-1:0] presc_q, presc_d;
  digit_t        digit_q, digit_d;
  bcd_val_t      pend_q, pend_d, act_q, act_d;
  logic          pvld_q, pvld_d;
  logic          slot_end, commit;

  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic [6:0]    seg_nxt;
  logic [2:0]    an_nxt;

  assign slot_end = (presc_q == PW'(SCAN_DIV - 1));
  assign commit   = slot_end && (digit_q == DIG_HUND);

  // Scan state and buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      digit_q <= DIG_ONES;
      pend_q  <= '0;
      act_q   <= '0;
      pvld_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      digit_q <= digit_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      pvld_q  <= pvld_d;
    end
  end

  // Prescaler/digit advance and double-buffer update
  always_comb begin
    presc_d = presc_q + PW'(1);
    digit_d = digit_q;
    pend_d  = pend_q;
    pvld_d  = pvld_q;
    act_d   = act_q;
    if (slot_end) begin
      presc_d = '0;
      case (digit_q)
        DIG_ONES: digit_d = DIG_TENS;
        DIG_TENS: digit_d = DIG_HUND;
        default:  digit_d = DIG_ONES;
      endcase
    end
    if (commit) begin
      // A load landing on the commit edge bypasses the pending buffer.
      pvld_d = 1'b0;
      if (load)
        act_d = {cout_in, sum_in};
      else if (pvld_q)
        act_d = pend_q;
    end else if (load) begin
      pend_d = {cout_in, sum_in};
      pvld_d = 1'b1;
    end
  end

  bcd_to_seg7 u_glyph (
    .nib     (nib),
    .glyph_c (glyph)
  );

  // Digit select, leading-zero blanking and anti-ghost anode gap
  always_comb begin
    nib     = act_q.ones;
    seg_nxt = SEG_BLANK;
    an_nxt  = 3'b000;
    case (digit_q)
      DIG_ONES: begin
        nib     = act_q.ones;
        seg_nxt = glyph;
        an_nxt  = 3'b001;
      end
      DIG_TENS: begin
        nib     = act_q.tens;
        seg_nxt = (!act_q.cout && act_q.tens == 4'd0) ? SEG_BLANK : glyph;
        an_nxt  = 3'b010;
      end
      default: begin
        seg_nxt = act_q.cout ? SEG_1 : SEG_BLANK;
        an_nxt  = 3'b100;
      end
    endcase
    if (presc_q < PW'(BLANK_CYC))
      an_nxt = 3'b000;
  end

  // Output registers; polarity applied after blanking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_OFF;
      dp  <= SEG_ACTIVE_LOW;
      an  <= AN_OFF;
    end else begin
      seg <= SEG_ACTIVE_LOW ? ~seg_nxt : seg_nxt;
      dp  <= SEG_ACTIVE_LOW;
      an  <= AN_ACTIVE_LOW ? ~an_nxt : an_nxt;
    end
  end

  assign frame_tick = commit;
  assign bcd_err    = (act_q.tens > BCD_MAX) | (act_q.ones > BCD_MAX);

endmodule
